// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit.
// This file holds the opcode and ALU-op encodings and the control bundle
// that is carried from D through X.
package ctrl_pkg;

    localparam int CTRL_REGW   = 5;
    localparam int CTRL_ALUOPW = 5;

    localparam logic [4:0] OP_ALU  = 5'd0;
    localparam logic [4:0] OP_J    = 5'd1;
    localparam logic [4:0] OP_BNE  = 5'd2;
    localparam logic [4:0] OP_JAL  = 5'd3;
    localparam logic [4:0] OP_JR   = 5'd4;
    localparam logic [4:0] OP_ADDI = 5'd5;
    localparam logic [4:0] OP_BLT  = 5'd6;
    localparam logic [4:0] OP_SW   = 5'd7;
    localparam logic [4:0] OP_LW   = 5'd8;
    localparam logic [4:0] OP_SETX = 5'd21;
    localparam logic [4:0] OP_BEX  = 5'd22;

    localparam logic [CTRL_ALUOPW-1:0] ALU_ADD = 5'd0;
    localparam logic [CTRL_ALUOPW-1:0] ALU_SUB = 5'd1;
    localparam logic [CTRL_ALUOPW-1:0] ALU_MUL = 5'd6;
    localparam logic [CTRL_ALUOPW-1:0] ALU_DIV = 5'd7;

    // Per-instruction control. The all-zero value is a bubble.
    typedef struct packed {
        logic                   reg_we;
        logic                   alu_imm;
        logic                   ram_we;
        logic                   ram_rd;
        logic [CTRL_ALUOPW-1:0] alu_op;
        logic [CTRL_REGW-1:0]   dest;
        logic                   is_md;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_decode.sv
// D-stage instruction decoder.
// This module is purely combinational. It turns the opcode fields into a
// control bundle and reports which source registers the instruction reads,
// so that the top level can detect load-use hazards.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic [4:0]             opcode,
    input  logic [CTRL_ALUOPW-1:0] alu_op,
    input  logic [CTRL_REGW-1:0]   rd,
    output ctrl_t                  ctrl,
    output logic                   read_rd,
    output logic                   reads_rs,
    output logic                   reads_op2
);

    // Decode table. Any opcode that is not recognised falls back to an all-zero NOP.
    always_comb begin
        ctrl        = CTRL_NOP;
        ctrl.dest   = rd;
        ctrl.alu_op = ALU_ADD;
        read_rd     = 1'b0;
        reads_rs    = 1'b0;
        reads_op2   = 1'b0;
        case (opcode)
            OP_ALU: begin
                ctrl.reg_we = 1'b1;
                ctrl.alu_op = alu_op;
                ctrl.is_md  = (alu_op == ALU_MUL) || (alu_op == ALU_DIV);
                reads_rs    = 1'b1;
                reads_op2   = 1'b1;
            end
            OP_J, OP_BEX: begin
                ctrl.reg_we = 1'b0;
            end
            OP_BNE, OP_BLT: begin
                ctrl.alu_op = ALU_SUB;
                read_rd     = 1'b1;
                reads_rs    = 1'b1;
                reads_op2   = 1'b1;
            end
            OP_JAL: begin
                ctrl.reg_we = 1'b1;
                ctrl.dest   = CTRL_REGW'(LINK_REG);
            end
            OP_JR: begin
                read_rd   = 1'b1;
                reads_rs  = 1'b1;
                reads_op2 = 1'b1;
            end
            OP_ADDI: begin
                ctrl.reg_we  = 1'b1;
                ctrl.alu_imm = 1'b1;
                reads_rs     = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_imm = 1'b1;
                ctrl.ram_we  = 1'b1;
                read_rd      = 1'b1;
                reads_rs     = 1'b1;
                reads_op2    = 1'b1;
            end
            OP_LW: begin
                ctrl.reg_we  = 1'b1;
                ctrl.alu_imm = 1'b1;
                ctrl.ram_rd  = 1'b1;
                reads_rs     = 1'b1;
            end
            OP_SETX: begin
                ctrl.reg_we = 1'b1;
                ctrl.dest   = CTRL_REGW'(STATUS_REG);
            end
            default: begin
                ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit.
// It decodes the D-stage instruction and carries its control through the
// X, M and W registers. Three interlocks are handled here: the multi-cycle
// multdiv hold, the taken-branch flush and the load-use stall.
// The widths of the control bundle are fixed by ctrl_pkg, so any override
// of REGW or ALUOPW must match the package widths.
module pipe_ctrl
    import ctrl_pkg::*;
#(
    parameter int REGW       = 5,
    parameter int ALUOPW     = 5,
    parameter int MD_LATENCY = 17,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [4:0]        d_opcode,
    input  logic [ALUOPW-1:0] d_alu_op,
    input  logic [REGW-1:0]   d_rd,
    input  logic [REGW-1:0]   d_rs,
    input  logic [REGW-1:0]   d_rt,
    input  logic              x_branch_taken,
    output logic              d_read_rd,
    output logic              stall_fd,
    output logic              flush_fd,
    output logic              x_valid,
    output logic [ALUOPW-1:0] x_alu_op,
    output logic              x_alu_imm,
    output logic              x_md_start,
    output logic              md_busy,
    output logic              m_valid,
    output logic              m_ram_we,
    output logic              m_ram_rd,
    output logic              w_valid,
    output logic              w_reg_we,
    output logic [REGW-1:0]   w_dest,
    output logic              w_from_ram
);

    localparam int             MDW     = $clog2(MD_LATENCY);
    localparam logic [MDW-1:0] MD_LOAD = MDW'(MD_LATENCY - 1);

    ctrl_t           d_ctrl;
    ctrl_t           x_ctrl;
    logic            d_reads_rs;
    logic            d_reads_op2;
    logic [REGW-1:0] d_op2;
    logic [MDW-1:0]  md_cnt;
    logic            load_use;
    logic            branch_flush;
    logic            x_load;
    logic            m_reg_we;
    logic [REGW-1:0] m_dest;
    logic            w_reg_we_raw;

    ctrl_decode #(
        .LINK_REG   (LINK_REG),
        .STATUS_REG (STATUS_REG)
    ) u_decode (
        .opcode    (d_opcode),
        .alu_op    (d_alu_op),
        .rd        (d_rd),
        .ctrl      (d_ctrl),
        .read_rd   (d_read_rd),
        .reads_rs  (d_reads_rs),
        .reads_op2 (d_reads_op2)
    );

    // The second read port uses rd for stores, branches and jr.
    // The hazard compare has to look at the same register.
    assign d_op2 = d_read_rd ? d_rd : d_rt;

    assign md_busy = (md_cnt != '0);

    // Only a counter that has just been loaded holds MD_LOAD, so this flags
    // the first X cycle of a multdiv.
    assign x_md_start = x_valid && x_ctrl.is_md && (md_cnt == MD_LOAD);

    assign load_use = x_valid && x_ctrl.ram_rd && (x_ctrl.dest != '0) && d_valid &&
                      ((d_reads_rs  && (d_rs  == x_ctrl.dest)) ||
                       (d_reads_op2 && (d_op2 == x_ctrl.dest)));

    assign branch_flush = x_branch_taken && x_valid && !md_busy;

    // The multdiv hold overrides everything. A flush discards the D
    // instruction, so a load-use stall on that same instruction is moot.
    assign stall_fd = md_busy || (load_use && !branch_flush);
    assign flush_fd = branch_flush;
    assign x_load   = !md_busy && !branch_flush && !load_use;

    assign x_alu_op  = x_ctrl.alu_op;
    assign x_alu_imm = x_ctrl.alu_imm;
    assign w_reg_we  = w_valid && w_reg_we_raw && (w_dest != '0);

    // X register: it holds during a multdiv and takes a bubble on a flush or a load-use stall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_valid <= 1'b0;
            x_ctrl  <= CTRL_NOP;
        end else if (!md_busy) begin
            if (x_load && d_valid) begin
                x_valid <= 1'b1;
                x_ctrl  <= d_ctrl;
            end else begin
                x_valid <= 1'b0;
                x_ctrl  <= CTRL_NOP;
            end
        end
    end

    // Multdiv occupancy counter: it is loaded when a mul/div enters X and counts down to zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            md_cnt <= '0;
        end else if (md_busy) begin
            md_cnt <= md_cnt - 1'b1;
        end else if (x_load && d_valid && d_ctrl.is_md) begin
            md_cnt <= MD_LOAD;
        end
    end

    // M register: it takes a bubble while X is held by a multdiv.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_valid  <= 1'b0;
            m_reg_we <= 1'b0;
            m_ram_we <= 1'b0;
            m_ram_rd <= 1'b0;
            m_dest   <= '0;
        end else if (md_busy) begin
            m_valid  <= 1'b0;
            m_reg_we <= 1'b0;
            m_ram_we <= 1'b0;
            m_ram_rd <= 1'b0;
            m_dest   <= '0;
        end else begin
            m_valid  <= x_valid;
            m_reg_we <= x_ctrl.reg_we;
            m_ram_we <= x_ctrl.ram_we;
            m_ram_rd <= x_ctrl.ram_rd;
            m_dest   <= x_ctrl.dest;
        end
    end

    // W register: it always advances from M.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_valid      <= 1'b0;
            w_reg_we_raw <= 1'b0;
            w_dest       <= '0;
            w_from_ram   <= 1'b0;
        end else begin
            w_valid      <= m_valid;
            w_reg_we_raw <= m_reg_we;
            w_dest       <= m_dest;
            w_from_ram   <= m_ram_rd;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl.
// It runs a decode vector table, hand-written interlock sequences and a
// randomized run against an instruction-timeline reference model.
module tb_pipe_ctrl;

    localparam int MD_LAT = 17;

    logic       clock = 1'b0;
    logic       reset;
    logic       d_valid;
    logic [4:0] d_opcode, d_alu_op, d_rd, d_rs, d_rt;
    logic       x_branch_taken;
    logic       d_read_rd, stall_fd, flush_fd, x_valid, x_alu_imm, x_md_start, md_busy;
    logic [4:0] x_alu_op, w_dest;
    logic       m_valid, m_ram_we, m_ram_rd, w_valid, w_reg_we, w_from_ram;

    int pass_cnt  = 0;
    int check_cnt = 0;

    typedef struct {
        logic [4:0] op, aop, rd, rs, rt;
        logic       e_read_rd, e_alu_imm;
        logic [4:0] e_alu_op;
        logic       e_ram_we, e_ram_rd, e_reg_we, e_from_ram;
        logic [4:0] e_dest;
    } vec_t;

    // One accepted instruction: the cycle it enters X and how long it stays there.
    typedef struct {
        logic [4:0] op, aop, rd;
        int         entry;
        int         occ;
    } rec_t;

    rec_t       q[$];
    int         cyc_n;
    logic [4:0] op_pool [0:14] = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd8, 5'd8, 5'd7, 5'd2,
                                   5'd6, 5'd4, 5'd1, 5'd3, 5'd21, 5'd22, 5'd9};

    always #5 clock = ~clock;

    pipe_ctrl #(.REGW(5), .ALUOPW(5), .MD_LATENCY(MD_LAT), .LINK_REG(31), .STATUS_REG(30)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid), .d_opcode(d_opcode),
        .d_alu_op(d_alu_op), .d_rd(d_rd), .d_rs(d_rs), .d_rt(d_rt),
        .x_branch_taken(x_branch_taken), .d_read_rd(d_read_rd), .stall_fd(stall_fd),
        .flush_fd(flush_fd), .x_valid(x_valid), .x_alu_op(x_alu_op), .x_alu_imm(x_alu_imm),
        .x_md_start(x_md_start), .md_busy(md_busy), .m_valid(m_valid), .m_ram_we(m_ram_we),
        .m_ram_rd(m_ram_rd), .w_valid(w_valid), .w_reg_we(w_reg_we), .w_dest(w_dest),
        .w_from_ram(w_from_ram)
    );

    // Instruction properties as listed in the opcode table.
    function automatic bit f_reg_we(input logic [4:0] op);
        return op inside {5'd0, 5'd5, 5'd8, 5'd3, 5'd21};
    endfunction
    function automatic bit f_known(input logic [4:0] op);
        return op inside {[5'd0:5'd8], 5'd21, 5'd22};
    endfunction
    function automatic logic [4:0] f_dest(input logic [4:0] op, input logic [4:0] rd);
        if (op == 5'd3) return 5'd31;
        if (op == 5'd21) return 5'd30;
        return f_known(op) ? rd : 5'd0;
    endfunction
    function automatic bit f_read_rd(input logic [4:0] op);
        return op inside {5'd7, 5'd2, 5'd6, 5'd4};
    endfunction
    function automatic bit f_reads_rs(input logic [4:0] op);
        return op inside {5'd0, 5'd5, 5'd7, 5'd8, 5'd2, 5'd6, 5'd4};
    endfunction
    function automatic bit f_reads_op2(input logic [4:0] op);
        return op inside {5'd0, 5'd7, 5'd2, 5'd6, 5'd4};
    endfunction
    function automatic bit f_is_md(input logic [4:0] op, input logic [4:0] aop);
        return (op == 5'd0) && (aop inside {5'd6, 5'd7});
    endfunction

    // Locate the instructions occupying X, M and W in cycle cyc_n.
    // Then apply the interlock rules to the current D inputs.
    function automatic void modelExpect(output logic [12:0] ev, output bit acc);
        bit         hx, hm, hw, busy, start, flush, lu, stall, wwe;
        rec_t       xr, mr, wr;
        logic [4:0] xd, op2, wd;
        hx = 0; hm = 0; hw = 0;
        foreach (q[i]) begin
            if (cyc_n >= q[i].entry && cyc_n < q[i].entry + q[i].occ) begin hx = 1; xr = q[i]; end
            if (cyc_n == q[i].entry + q[i].occ) begin hm = 1; mr = q[i]; end
            if (cyc_n == q[i].entry + q[i].occ + 1) begin hw = 1; wr = q[i]; end
        end
        busy  = hx && (cyc_n < xr.entry + xr.occ - 1);
        start = hx && f_is_md(xr.op, xr.aop) && (cyc_n == xr.entry);
        flush = x_branch_taken && hx && !busy;
        xd    = hx ? f_dest(xr.op, xr.rd) : 5'd0;
        op2   = f_read_rd(d_opcode) ? d_rd : d_rt;
        lu    = hx && (xr.op == 5'd8) && (xd != 5'd0) && d_valid &&
                ((f_reads_rs(d_opcode) && d_rs == xd) || (f_reads_op2(d_opcode) && op2 == xd));
        stall = busy || (lu && !flush);
        acc   = d_valid && !stall && !flush;
        wwe   = hw && f_reg_we(wr.op) && (f_dest(wr.op, wr.rd) != 5'd0);
        wd    = hw ? f_dest(wr.op, wr.rd) : 5'd0;
        ev    = {f_read_rd(d_opcode), stall, flush, hx, busy, start, hm, wwe, wd};
        if (hm && mr.occ < 0) ev = '0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic dv, input logic [4:0] op, input logic [4:0] aop,
                                 input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                                 input logic xbt);
        d_valid = dv; d_opcode = op; d_alu_op = aop;
        d_rd = rd; d_rs = rs; d_rt = rt; x_branch_taken = xbt;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic randInstr();
        logic [4:0] op;
        op = op_pool[$urandom_range(0, 14)];
        d_opcode = op;
        if (op == 5'd0 && $urandom_range(0, 11) == 0) d_alu_op = ($urandom_range(0, 1) == 0) ? 5'd6 : 5'd7;
        else d_alu_op = 5'($urandom_range(0, 5));
        d_rd = 5'($urandom_range(0, 3));
        d_rs = 5'($urandom_range(0, 3));
        d_rt = 5'($urandom_range(0, 3));
        d_valid = ($urandom_range(0, 9) != 0);
    endtask

    initial begin
        vec_t       vecs[$];
        logic [12:0] ev;
        bit         acc;
        int         starts, busy_n, stall_n, m_first;

        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("reset_state", 32'({stall_fd, flush_fd, x_valid, x_md_start, md_busy, m_valid,
                    m_ram_we, m_ram_rd, w_valid, w_reg_we, w_dest, w_from_ram, x_alu_op, x_alu_imm}), 32'd0);
        reset = 1'b1;
        tick();

        // op aop rd rs rt | read_rd alu_imm alu_op ram_we ram_rd reg_we from_ram dest
        vecs.push_back('{5'd7,  5'd0, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5});
        vecs.push_back('{5'd3,  5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd31});
        vecs.push_back('{5'd5,  5'd3, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd1});
        vecs.push_back('{5'd0,  5'd1, 5'd2, 5'd1, 5'd1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd2});
        vecs.push_back('{5'd8,  5'd0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3});
        vecs.push_back('{5'd2,  5'd0, 5'd6, 5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd6});
        vecs.push_back('{5'd6,  5'd4, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7});
        vecs.push_back('{5'd21, 5'd0, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd30});
        vecs.push_back('{5'd4,  5'd0, 5'd3, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3});
        vecs.push_back('{5'd9,  5'd2, 5'd5, 5'd1, 5'd1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
        vecs.push_back('{5'd0,  5'd0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
        vecs.push_back('{5'd22, 5'd0, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2});
        vecs.push_back('{5'd1,  5'd0, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1});

        foreach (vecs[i]) begin
            applyStimulus(1, vecs[i].op, vecs[i].aop, vecs[i].rd, vecs[i].rs, vecs[i].rt, 0);
            @(negedge clock);
            checkOutput($sformatf("vec%0d_read_rd", i), 32'(d_read_rd), 32'(vecs[i].e_read_rd));
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
            @(negedge clock);
            checkOutput($sformatf("vec%0d_x", i), 32'({x_valid, x_alu_imm, x_alu_op}),
                        32'({1'b1, vecs[i].e_alu_imm, vecs[i].e_alu_op}));
            tick();
            @(negedge clock);
            checkOutput($sformatf("vec%0d_m", i), 32'({m_valid, m_ram_we, m_ram_rd}),
                        32'({1'b1, vecs[i].e_ram_we, vecs[i].e_ram_rd}));
            tick();
            @(negedge clock);
            checkOutput($sformatf("vec%0d_w", i), 32'({w_valid, w_reg_we, w_dest, w_from_ram}),
                        32'({1'b1, vecs[i].e_reg_we, vecs[i].e_dest, vecs[i].e_from_ram}));
            tick();
        end
        idle(3);

        // addi r1 followed by add r2,r1,r1: no stall, and both write back in consecutive cycles
        applyStimulus(1, 5'd5, 5'd0, 5'd1, 5'd0, 5'd0, 0);
        @(negedge clock); checkOutput("fwd_addi_stall", 32'(stall_fd), 32'd0);
        tick();
        applyStimulus(1, 5'd0, 5'd0, 5'd2, 5'd1, 5'd1, 0);
        @(negedge clock); checkOutput("fwd_add_stall", 32'(stall_fd), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clock); checkOutput("fwd_wb1", 32'({w_reg_we, w_dest}), 32'({1'b1, 5'd1}));
        tick();
        @(negedge clock); checkOutput("fwd_wb2", 32'({w_reg_we, w_dest}), 32'({1'b1, 5'd2}));
        idle(3);

        // lw r3 followed by add r4,r3,r0: exactly one stall cycle with a bubble in X
        applyStimulus(1, 5'd8, 5'd0, 5'd3, 5'd1, 5'd0, 0);
        tick();
        applyStimulus(1, 5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 0);
        @(negedge clock); checkOutput("lu_stall", 32'({stall_fd, x_valid}), 32'b11);
        tick();
        @(negedge clock); checkOutput("lu_bubble", 32'({stall_fd, x_valid}), 32'b00);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        @(negedge clock); checkOutput("lu_issue", 32'({x_valid, x_alu_op}), 32'({1'b1, 5'd0}));
        idle(3);

        // lw r0 followed by add r4,r0,r0: r0 never causes a stall
        applyStimulus(1, 5'd8, 5'd0, 5'd0, 5'd1, 5'd0, 0);
        tick();
        applyStimulus(1, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 0);
        @(negedge clock); checkOutput("lu_r0_nostall", 32'(stall_fd), 32'd0);
        idle(3);

        // mul: hold X for MD_LAT cycles
        starts = 0; busy_n = 0; stall_n = 0; m_first = -1;
        for (int c = 0; c < 25; c++) begin
            if (c == 0) applyStimulus(1, 5'd0, 5'd6, 5'd5, 5'd1, 5'd2, 0);
            else applyStimulus(0, 0, 0, 0, 0, 0, 0);
            @(negedge clock);
            if (x_md_start) starts++;
            if (md_busy) busy_n++;
            if (stall_fd) stall_n++;
            if (m_valid && m_first < 0) m_first = c;
            tick();
        end
        checkOutput("mul_start_pulses", 32'(starts), 32'd1);
        checkOutput("mul_busy_cycles", 32'(busy_n), 32'(MD_LAT - 1));
        checkOutput("mul_stall_cycles", 32'(stall_n), 32'(MD_LAT - 1));
        checkOutput("mul_reaches_m", 32'(m_first), 32'(MD_LAT + 1));
        idle(3);

        // A taken branch with lw in X and a dependent instruction in D flushes instead of stalling
        applyStimulus(1, 5'd8, 5'd0, 5'd3, 5'd1, 5'd0, 0);
        tick();
        applyStimulus(1, 5'd0, 5'd0, 5'd4, 5'd3, 5'd0, 1);
        @(negedge clock); checkOutput("br_flush", 32'({flush_fd, stall_fd}), 32'b10);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge clock); checkOutput("br_bubble_ignore", 32'({x_valid, flush_fd}), 32'b00);
        idle(3);

        // Reset asserted during cycle 5 of a div
        applyStimulus(1, 5'd0, 5'd7, 5'd6, 5'd1, 5'd2, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (4) tick();
        #2;
        checkOutput("div_busy_pre_reset", 32'({md_busy, x_valid}), 32'b11);
        reset = 1'b0;
        #1;
        checkOutput("div_reset_clear", 32'({stall_fd, flush_fd, x_valid, x_md_start, md_busy, m_valid,
                    m_ram_we, m_ram_rd, w_valid, w_reg_we, w_dest, w_from_ram, x_alu_op, x_alu_imm}), 32'd0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        tick();
        applyStimulus(1, 5'd0, 5'd0, 5'd9, 5'd1, 5'd2, 0);
        busy_n = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (c == 0) checkOutput("post_reset_idle", 32'({x_valid, md_busy, m_valid, w_valid, stall_fd}), 32'd0);
            if (md_busy) busy_n++;
            if (c == 3) checkOutput("post_reset_add_wb", 32'({w_reg_we, w_dest}), 32'({1'b1, 5'd9}));
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0, 0);
        end
        checkOutput("post_reset_no_busy", 32'(busy_n), 32'd0);
        idle(4);

        // Randomized run against the timeline model
        cyc_n = 0;
        q.delete();
        randInstr();
        x_branch_taken = 1'b0;
        for (int k = 0; k < 400; k++) begin
            while (q.size() > 0 && q[0].entry + q[0].occ + 1 < cyc_n) void'(q.pop_front());
            @(negedge clock);
            modelExpect(ev, acc);
            checkOutput($sformatf("rand_cyc%0d", k),
                        32'({d_read_rd, stall_fd, flush_fd, x_valid, md_busy, x_md_start, m_valid, w_reg_we, w_dest}),
                        32'(ev));
            @(posedge clock);
            if (acc) q.push_back('{d_opcode, d_alu_op, d_rd, cyc_n + 1,
                                   f_is_md(d_opcode, d_alu_op) ? MD_LAT : 1});
            cyc_n++;
            #1;
            if (!ev[11]) randInstr();
            x_branch_taken = ($urandom_range(0, 6) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipelined successor to the single-cycle control decoder: decodes the D-stage instruction into a control bundle and carries it through X, M and W pipeline registers.
- Adds interlocks that the single-cycle design does not need:
  - load-use stall;
  - multi-cycle multdiv hold;
  - taken-branch flush.
- Sits between the F/D latch and the datapath. It drives PC/F-D stall and flush signals and per-stage control.

Parameters:
- REGW, 5, register-specifier width.
- ALUOPW, 5, ALU opcode width.
- MD_LATENCY, 17, cycles the mul/div instruction occupies X (must be ≥2).
- LINK_REG, 31, destination register of jal.
- STATUS_REG, 30, destination register of setx.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- d_valid  in  1  D-stage instruction valid.
- d_opcode  in  5  D-stage opcode.
- d_alu_op  in  ALUOPW  D-stage ALU op field.
- d_rd  in  REGW  D-stage rd field.
- d_rs  in  REGW  D-stage rs field.
- d_rt  in  REGW  D-stage rt field.
- x_branch_taken  in  1  branch/jump resolved taken in X.
- d_read_rd  out  1  second regfile read port uses rd instead of rt (combinational).
- stall_fd  out  1  hold PC and the F/D latch.
- flush_fd  out  1  squash the F/D latch.
- x_valid  out  1  X-stage instruction valid.
- x_alu_op  out  ALUOPW  X-stage ALU op.
- x_alu_imm  out  1  X-stage ALU B operand is the immediate.
- x_md_start  out  1  one-cycle multdiv start pulse.
- md_busy  out  1  multdiv occupying X.
- m_valid  out  1  M-stage instruction valid.
- m_ram_we  out  1  M-stage RAM write enable.
- m_ram_rd  out  1  M-stage RAM read.
- w_valid  out  1  W-stage instruction valid.
- w_reg_we  out  1  W-stage regfile write enable.
- w_dest  out  REGW  W-stage write register.
- w_from_ram  out  1  W-stage writeback data comes from RAM.

Behaviour:
- Opcodes: ALU=0, j=1, bne=2, jal=3, jr=4, addi=5, blt=6, sw=7, lw=8, setx=21, bex=22. ALU ops: add=0, sub=1, mul=6, div=7.
- Decode (combinational, D stage):
  - reg_we = ALU | addi | lw | jal | setx.
  - alu_imm = addi | sw | lw.
  - ram_we = sw; ram_rd = lw.
  - read_rd = sw | bne | blt | jr.
  - alu_op = d_alu_op if opcode==0; sub for bne/blt; add otherwise.
  - dest = LINK_REG for jal; STATUS_REG for setx; d_rd otherwise.
  - Reads rs: ALU, addi, sw, lw, bne, blt, jr. Reads second operand: ALU, sw, bne, blt, jr.
  - Unknown opcode decodes to all-zero control (NOP).
- Reset (reset low, asynchronous):
  - all valids 0, all stage control 0;
  - md counter 0, md_busy 0;
  - stall_fd 0, flush_fd 0, x_md_start 0.
  - Reset mid-multdiv abandons it; first post-reset cycle is idle.
- Normal advance each cycle: D to X, X to M, M to W. No D→W latency beyond 3 register stages.
- Multdiv hold:
  - A valid ALU op mul/div entering X loads the counter with MD_LATENCY-1 and pulses x_md_start in its first X cycle.
  - While counter ≠ 0: md_busy=1, stall_fd=1, X holds, M receives a bubble, counter decrements.
  - When counter reaches 0, X advances normally next edge. Total X occupancy = MD_LATENCY cycles.
- Load-use stall:
  - Condition: X valid lw, X dest ≠ 0, and dest equals a register the valid D instruction actually reads. The second operand compares d_rd if read_rd, else d_rt.
  - Response: stall_fd=1 for exactly one cycle, bubble inserted into X.
- Branch flush:
  - Condition: x_branch_taken with x_valid and not md_busy.
  - Response: flush_fd=1 and bubble into X next edge.
  - x_branch_taken is ignored when x_valid=0.
- Priority when events coincide: md hold > branch flush > load-use stall. A flush squashes a load-use-stalled D instruction, so stall_fd=0 that cycle.
- w_reg_we is forced 0 when w_dest==0. d_valid=0 acts as a bubble.

Decomposition:
- Shared package ctrl_pkg:
  - opcode and ALU-op constants;
  - ctrl bundle typedef (reg_we, alu_imm, ram_we, ram_rd, alu_op, dest, is_md).
- One natural sub-module: ctrl_decode, the combinational D-stage decoder, instantiated once.

Test Plan:
- addi r1 then ALU add r2,r1,r1 back-to-back → no stall; w_reg_we=1 with w_dest=1, then w_dest=2 on consecutive cycles, 3 cycles after each issue.
- lw r3 then add r4,r3,r0 → stall_fd=1 for exactly 1 cycle, X bubble; lw r0 then add r4,r0,r0 → no stall.
- mul (alu_op 6) with MD_LATENCY=17 → x_md_start pulses once; md_busy and stall_fd high 16 cycles; m_valid=0 for 16 cycles; then mul reaches M.
- x_branch_taken=1 with lw in X and load-use-dependent instruction in D → flush_fd=1, stall_fd=0, next x_valid=0.
- reset asserted low during cycle 5 of a div → all outputs 0 immediately; after release, a new add flows with no md_busy.
- sw r5 → d_read_rd=1, x_alu_imm=1, m_ram_we=1, w_reg_we=0; jal → w_dest=31, w_reg_we=1.
